instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch_if.sv | 29 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/instruction_fetch.sv | 115 +++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU fetch definitions: default widths, buffer depth and the
// fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int IF_ADDR_W = 16;
    localparam int IF_DATA_W = 16;
    localparam int IF_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_if.sv
// Fetch unit bus: redirect input, memory read channel and decoder handshake.
// master = fetch unit, slave = execute/memory/decoder environment.
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int DATA_W = IF_DATA_W
);
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        input  jump, jump_addr, mem_ack, mem_data, inst_ready,
        output mem_req, mem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output jump, jump_addr, mem_ack, mem_data, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst, inst_pc
    );
endinterface : instruction_fetch_if

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, word} entries; head is read straight from
// registered storage and the valid flag is its own flop.
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = IF_DEPTH,
    parameter int WIDTH = IF_ADDR_W + IF_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    // storage, pointers, occupancy and head-valid registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // flush overrides push/pop; pointers wrap because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        valid_d = (count_d != {CNT_W{1'b0}});
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = valid_q;
    assign full       = (count_q == CNT_W'(DEPTH));

endmodule : fetch_fifo

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential fetch from fetch_pc into a small buffer,
// with redirect (jump) support that discards in-flight memory responses.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W     = IF_ADDR_W,
    parameter int                DATA_W     = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}},
    parameter int                DEPTH      = IF_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);
    fetch_state_e             state_q, state_d;
    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic                     mem_req_q, mem_req_d;
    logic                     push_s, pop_s, flush_s;
    logic                     full_s, head_valid_s;
    logic [ADDR_W+DATA_W-1:0] head_s;

    // FSM state, fetch address and memory request registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_ADDR;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
        end
    end

    // next state; outstanding requests only exist in WAIT, so in IDLE "not full" means room
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.jump) begin
                    // the jump flushes the buffer, so the redirected fetch can start at once
                    fetch_pc_d = bus.jump_addr;
                    state_d    = ST_WAIT;
                end else if (!full_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.jump) begin
                    fetch_pc_d = bus.jump_addr;
                    state_d    = bus.mem_ack ? ST_IDLE : ST_DISCARD;
                end else if (bus.mem_ack) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (bus.jump) begin
                    fetch_pc_d = bus.jump_addr;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                // the stale response ends the discard even if a new jump arrives with it
                if (bus.mem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                fetch_pc_d = RESET_ADDR;
            end
        endcase
        mem_req_d = (state_d == ST_WAIT);
    end

    // buffer control: a jump flushes and suppresses both push and pop
    always_comb begin
        flush_s = bus.jump;
        if ((state_q == ST_WAIT) && bus.mem_ack && !bus.jump) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s = head_valid_s & bus.inst_ready & ~bus.jump;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_s),
        .push       (push_s),
        .push_data  ({fetch_pc_q, bus.mem_data}),
        .pop        (pop_s),
        .head_data  (head_s),
        .head_valid (head_valid_s),
        .full       (full_s)
    );

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = fetch_pc_q;
    assign bus.inst_valid = head_valid_s;
    assign bus.inst       = head_s[DATA_W-1:0];
    assign bus.inst_pc    = head_s[ADDR_W+DATA_W-1:DATA_W];

endmodule : instruction_fetch
